// File: rtl/fifo_uart_pkg.sv
// ============================================================================
// fifo_uart_pkg : shared state encoding and sizing helpers for fifo_uart_tx
// Revision      : 1.0
// ============================================================================
`default_nettype none

package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Width of a counter/index that must hold 0..n-1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// uart_bit_timer : free-running 0..CLKS_PER_BIT-1 counter with clear and last_clk
// Revision       : 1.0
// ============================================================================
`default_nettype none

module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic last_clk
);

  localparam int CNT_W = idx_width(CLKS_PER_BIT);

  logic [CNT_W-1:0] count;

  assign last_clk = (count == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || last_clk) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// fifo_uart_tx : drains a FIFO read port and serialises each byte as a UART frame
//                Optional even-parity bit when FIFO_UART_TX_PARITY_EN is defined.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam int              CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int              IDX_W        = idx_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0]      bit_idx;
  logic                  last_clk;
  logic                  timer_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  // Holding the timer cleared in IDLE makes every state entry start at count 0.
  assign timer_clear = (state == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .last_clk(last_clk)
  );

  // Gated by reset so no pop can slip through while the FSM is held in reset.
  assign fifo_rd    = reset && !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && last_clk));
  assign tx_busy    = (state != IDLE);
  assign frame_done = (state == STOP) && last_clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      shift_reg  <= '0;
      bit_idx    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (fifo_rd) begin
      shift_reg  <= fifo_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= ^fifo_rd_data;
`endif
      bit_idx    <= '0;
      state      <= START;
      tx         <= 1'b0;
    end else if (last_clk) begin
      case (state)
        START: begin
          state <= DATA;
          tx    <= shift_reg[0];
        end
        DATA: begin
          shift_reg <= shift_reg >> 1;
          if (bit_idx == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= parity_bit;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= shift_reg[1];
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// tb_fifo_uart_tx : directed bench for fifo_uart_tx driving a small FIFO model
// Revision        : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME = 44;
`else
  localparam int FRAME = 40;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         bad_rd = 0;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd, tx, tx_busy, frame_done;

  logic tr_tx   [0:255];
  logic tr_rd   [0:255];
  logic tr_busy [0:255];
  logic tr_done [0:255];
  int   n_tr = 0;

  int n_checks = 0;
  int n_pass   = 0;

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = mem[rd_ptr[5:0]];

  fifo_uart_tx #(
    .DATA_WIDTH(DW),
    .CLK_FREQ  (16),
    .BAUD_RATE (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd     (fifo_rd),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fifo_empty) bad_rd = bad_rd + 1;
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr++;
  endtask

  // Samples 1ns after each falling edge; always returns on a falling edge.
  task automatic log_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      tr_tx[n_tr]   = tx;
      tr_rd[n_tr]   = fifo_rd;
      tr_busy[n_tr] = tx_busy;
      tr_done[n_tr] = frame_done;
      n_tr++;
      @(negedge clk);
    end
  endtask

  // sel: 0 fifo_rd, 1 tx_busy, 2 frame_done, 3 tx low
  function automatic int count_ones(input int sel, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0:       c += (tr_rd[i]   === 1'b1) ? 1 : 0;
        1:       c += (tr_busy[i] === 1'b1) ? 1 : 0;
        2:       c += (tr_done[i] === 1'b1) ? 1 : 0;
        default: c += (tr_tx[i]   !== 1'b1) ? 1 : 0;
      endcase
    end
    return c;
  endfunction

  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j < CPB) return 1'b0;
    if (j < CPB * (1 + DW)) return b[(j - CPB) / CPB];
`ifdef FIFO_UART_TX_PARITY_EN
    if (j < CPB * (2 + DW)) return ^b;
`endif
    return 1'b1;
  endfunction

  // Frame whose pop was sampled at index s: line bits occupy s+1 .. s+FRAME.
  task automatic check_frame(input string tag, input int s, input logic [7:0] b);
    logic [63:0] g, e;
    g = '0;
    e = '0;
    for (int j = 0; j < FRAME; j++) begin
      g[j] = tr_tx[s + 1 + j];
      e[j] = exp_bit(b, j);
    end
    check({tag, "_pop"}, {63'd0, tr_rd[s]}, 64'd1);
    check({tag, "_tx"}, g, e);
    check({tag, "_done"}, {63'd0, tr_done[s + FRAME]}, 64'd1);
  endtask

  initial begin
    int p0;

    // 1: reset and idle
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx",   {63'd0, tx},         64'd1);
    check("rst_busy", {63'd0, tx_busy},    64'd0);
    check("rst_rd",   {63'd0, fifo_rd},    64'd0);
    check("rst_done", {63'd0, frame_done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    n_tr = 0;
    log_cycles(50);
    check("idle_quiet", 64'(count_ones(0, 0, 49) + count_ones(1, 0, 49) +
                            count_ones(3, 0, 49)), 64'd0);

    // 2: single byte 0xA5
    n_tr = 0;
    p0 = rd_ptr;
    push(8'hA5);
    log_cycles(FRAME + 5);
    check_frame("a5", 0, 8'hA5);
    check("a5_pops",  64'(rd_ptr - p0), 64'd1);
    check("a5_rdcnt", 64'(count_ones(0, 0, FRAME + 4)), 64'd1);
    check("a5_dcnt",  64'(count_ones(2, 0, FRAME + 4)), 64'd1);
    check("a5_busy",  64'(count_ones(1, 0, FRAME + 4)), 64'(FRAME));

    // 3: three preloaded bytes, back to back
    n_tr = 0;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    log_cycles(3 * FRAME + 5);
    check_frame("b2b0", 0,         8'h00);
    check_frame("b2b1", FRAME,     8'hFF);
    check_frame("b2b2", 2 * FRAME, 8'h55);
    check("b2b_busy",  64'(count_ones(1, 1, 3 * FRAME)), 64'(3 * FRAME));
    check("b2b_end",   {63'd0, tr_busy[3 * FRAME + 1]}, 64'd0);
    check("b2b_rdcnt", 64'(count_ones(0, 0, 3 * FRAME + 4)), 64'd3);

    // 4: reset during DATA bit 3 (samples 17..20) of 0xF0, then 0x81 sent whole
    n_tr = 0;
    push(8'hF0);
    push(8'h81);
    log_cycles(18);
    check("mid_tx_low", {63'd0, tr_tx[17]}, 64'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_tx",   {63'd0, tx},      64'd1);
    check("mid_rst_busy", {63'd0, tx_busy}, 64'd0);
    check("mid_rst_rd",   {63'd0, fifo_rd}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    n_tr = 0;
    log_cycles(FRAME + 5);
    check_frame("after_rst", 0, 8'h81);
    check("after_rst_rdcnt", 64'(count_ones(0, 0, FRAME + 4)), 64'd1);

    // 5: second byte arrives during STOP; third arrives right after frame_done
    n_tr = 0;
    push(8'h5A);
    log_cycles(FRAME - 2);
    push(8'hC3);
    log_cycles(FRAME + 3);
    push(8'h96);
    log_cycles(FRAME + 5);
    check_frame("late0", 0,             8'h5A);
    check_frame("late1", FRAME,         8'hC3);
    check_frame("late2", 2 * FRAME + 1, 8'h96);
    check("late_gap_busy", {63'd0, tr_busy[2 * FRAME + 1]}, 64'd0);
    check("late_gap_tx",   {63'd0, tr_tx[2 * FRAME + 1]},   64'd1);
    check("late_rdcnt",    64'(count_ones(0, 0, 3 * FRAME + 5)), 64'd3);

`ifdef FIFO_UART_TX_PARITY_EN
    // 6: even parity bits
    n_tr = 0;
    push(8'h07);
    push(8'h03);
    log_cycles(2 * FRAME + 5);
    check_frame("par07", 0,     8'h07);
    check_frame("par03", FRAME, 8'h03);
    check("par07_bit", {63'd0, tr_tx[37]},         64'd1);
    check("par03_bit", {63'd0, tr_tx[FRAME + 37]}, 64'd0);
`endif

    check("no_pop_empty", 64'(bad_rd), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
